// File: rtl/cl_bud_axi_sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// cl_bud_axi_sram_ctrl_if
//
// AXI4 bus bundle between the AXI-L to AXI4 bridge (master) and the bud SRAM
// controller (slave). Carries the five AXI4 channels with 64-bit data beats.
//
// Signals (master -> slave unless noted):
//   AW : awid, awaddr, awlen, awsize, awburst, awvalid ; awready (slave->master)
//   W  : wdata, wstrb, wlast, wvalid ; wready (slave->master)
//   B  : bid, bresp, bvalid (slave->master) ; bready
//   AR : arid, araddr, arlen, arsize, arburst, arvalid ; arready (slave->master)
//   R  : rid, rdata, rresp, rlast, rvalid (slave->master) ; rready
// -----------------------------------------------------------------------------
interface cl_bud_axi_sram_ctrl_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    // Write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    // Write data channel
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    // Write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    // Read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/cl_bud_axi_sram_ctrl.sv
// -----------------------------------------------------------------------------
// cl_bud_axi_sram_ctrl
//
// AXI4 slave memory controller for bud. Accepts one INCR/FIXED burst of 64-bit
// beats at a time, stores it in an inferred single-port SRAM and returns read
// bursts at one beat per cycle through a 2-entry read buffer. Malformed or
// out-of-range bursts are answered with SLVERR (no SRAM writes, zero read data).
//
// Ports:
//   clk        : sole clock, rising edge
//   sync_rst_n : synchronous active-low reset
//   s_axi      : AXI4 slave modport (AW, W, B, AR, R channels)
//
// Parameters:
//   ID_WIDTH   : AXI ID width
//   ADDR_WIDTH : byte address width
//   MEM_DEPTH  : SRAM depth in 64-bit words (power of two)
// -----------------------------------------------------------------------------
module cl_bud_axi_sram_ctrl #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                   clk,
    input  logic                   sync_rst_n,
    cl_bud_axi_sram_ctrl_if.slave  s_axi
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int SW     = ADDR_WIDTH - 3;   // word index width

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [SW:0] DEPTH_C = (SW+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Transaction context
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]          len_q, len_d;
    logic                fixed_q, fixed_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic [8:0]          beat_q, beat_d;     // write beat / read issue counter
    logic                addr_err_q, addr_err_d;
    logic                wlast_err_q, wlast_err_d;
    logic                last_grant_rd_q, last_grant_rd_d;

    // Read buffer (2 entries)
    logic [1:0]          buf_cnt_q, buf_cnt_d;
    logic                buf_wr_ptr_q, buf_wr_ptr_d;
    logic                buf_rd_ptr_q, buf_rd_ptr_d;
    logic [63:0]         buf_data_q [2];
    logic                buf_last_q [2];

    logic [63:0]         mem [MEM_DEPTH];

    // Combinational handshake / control
    logic                aw_grant, ar_grant;
    logic                awready_c, arready_c, wready_c, bvalid_c, rvalid_c;
    logic                mem_we, rd_issue, rd_pop;
    logic                beat_is_last, beats_left;

    // Address-phase decode, shared by both channels
    logic [ID_WIDTH-1:0] a_id;
    logic [SW-1:0]       a_start;
    logic [7:0]          a_len;
    logic [2:0]          a_size;
    logic [1:0]          a_burst;
    logic [SW:0]         a_end;
    logic                a_err;

    // Write wins a contest only if the previous grant went to read
    assign aw_grant = s_axi.awvalid && (!s_axi.arvalid || last_grant_rd_q);
    assign ar_grant = s_axi.arvalid && !aw_grant;

    always_comb begin
        if (aw_grant) begin
            a_id    = s_axi.awid;
            a_start = s_axi.awaddr[ADDR_WIDTH-1:3];
            a_len   = s_axi.awlen;
            a_size  = s_axi.awsize;
            a_burst = s_axi.awburst;
        end else begin
            a_id    = s_axi.arid;
            a_start = s_axi.araddr[ADDR_WIDTH-1:3];
            a_len   = s_axi.arlen;
            a_size  = s_axi.arsize;
            a_burst = s_axi.arburst;
        end
    end

    // Last word index of an INCR burst, one bit wider so it cannot wrap
    assign a_end = {1'b0, a_start} + (SW+1)'(a_len);

    assign a_err = (a_size != 3'd3)
                || a_burst[1]
                || ((a_burst == BURST_INCR)  && (a_end >= DEPTH_C))
                || ((a_burst == BURST_FIXED) && ({1'b0, a_start} >= DEPTH_C));

    assign beat_is_last = (beat_q == {1'b0, len_q});
    assign beats_left   = (beat_q <= {1'b0, len_q});
    assign rvalid_c     = (buf_cnt_q != 2'd0);

    // Next-state and handshake logic
    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        len_d           = len_q;
        fixed_d         = fixed_q;
        idx_d           = idx_q;
        beat_d          = beat_q;
        addr_err_d      = addr_err_q;
        wlast_err_d     = wlast_err_q;
        last_grant_rd_d = last_grant_rd_q;
        awready_c       = 1'b0;
        arready_c       = 1'b0;
        wready_c        = 1'b0;
        bvalid_c        = 1'b0;
        mem_we          = 1'b0;
        rd_issue        = 1'b0;
        rd_pop          = 1'b0;

        case (state_q)
            IDLE: begin
                awready_c = aw_grant;
                arready_c = ar_grant;
                if (aw_grant || ar_grant) begin
                    id_d            = a_id;
                    len_d           = a_len;
                    fixed_d         = (a_burst == BURST_FIXED);
                    idx_d           = a_start[MEM_AW-1:0];
                    beat_d          = 9'd0;
                    addr_err_d      = a_err;
                    wlast_err_d     = 1'b0;
                    last_grant_rd_d = ar_grant;
                    state_d         = aw_grant ? WR_DATA : RD_DATA;
                end
            end

            WR_DATA: begin
                wready_c = 1'b1;
                if (s_axi.wvalid) begin
                    mem_we = !addr_err_q;
                    // The burst length, not wlast, ends the burst; a misplaced
                    // wlast only poisons the response.
                    if (s_axi.wlast != beat_is_last) begin
                        wlast_err_d = 1'b1;
                    end
                    if (!fixed_q) begin
                        idx_d = idx_q + MEM_AW'(1);
                    end
                    beat_d = beat_q + 9'd1;
                    if (beat_is_last) begin
                        state_d = WR_RESP;
                    end
                end
            end

            WR_RESP: begin
                bvalid_c = 1'b1;
                if (s_axi.bready) begin
                    state_d = IDLE;
                end
            end

            RD_DATA: begin
                rd_pop = rvalid_c && s_axi.rready;
                // Issue only while a buffer slot is guaranteed free next cycle
                if (beats_left && (buf_cnt_q < 2'd2)) begin
                    rd_issue = 1'b1;
                    if (!fixed_q) begin
                        idx_d = idx_q + MEM_AW'(1);
                    end
                    beat_d = beat_q + 9'd1;
                end
                if (rd_pop && buf_last_q[buf_rd_ptr_q]) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Read buffer occupancy and pointers
    always_comb begin
        buf_cnt_d    = buf_cnt_q;
        buf_wr_ptr_d = buf_wr_ptr_q;
        buf_rd_ptr_d = buf_rd_ptr_q;
        case ({rd_issue, rd_pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
        if (rd_issue) begin
            buf_wr_ptr_d = ~buf_wr_ptr_q;
        end
        if (rd_pop) begin
            buf_rd_ptr_d = ~buf_rd_ptr_q;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q         <= IDLE;
            id_q            <= '0;
            beat_q          <= '0;
            addr_err_q      <= 1'b0;
            wlast_err_q     <= 1'b0;
            last_grant_rd_q <= 1'b1;
            buf_cnt_q       <= '0;
            buf_wr_ptr_q    <= 1'b0;
            buf_rd_ptr_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            beat_q          <= beat_d;
            addr_err_q      <= addr_err_d;
            wlast_err_q     <= wlast_err_d;
            last_grant_rd_q <= last_grant_rd_d;
            buf_cnt_q       <= buf_cnt_d;
            buf_wr_ptr_q    <= buf_wr_ptr_d;
            buf_rd_ptr_q    <= buf_rd_ptr_d;
        end
    end

    // Burst context, only meaningful while a transaction is active
    always_ff @(posedge clk) begin
        len_q   <= len_d;
        fixed_q <= fixed_d;
        idx_q   <= idx_d;
    end

    // SRAM and read buffer data; the read lands straight in the buffer so the
    // first beat is visible two cycles after the AR handshake.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            buf_data_q[buf_wr_ptr_q] <= addr_err_q ? 64'd0 : mem[idx_q];
            buf_last_q[buf_wr_ptr_q] <= beat_is_last;
        end
    end

    assign s_axi.awready = awready_c;
    assign s_axi.arready = arready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.bvalid  = bvalid_c;
    assign s_axi.bid     = id_q;
    assign s_axi.bresp   = (bvalid_c && (addr_err_q || wlast_err_q)) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rvalid  = rvalid_c;
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = rvalid_c ? buf_data_q[buf_rd_ptr_q] : 64'd0;
    assign s_axi.rlast   = rvalid_c && buf_last_q[buf_rd_ptr_q];
    assign s_axi.rresp   = (rvalid_c && addr_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_cl_bud_axi_sram_ctrl.sv
module tb_cl_bud_axi_sram_ctrl;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int MEM_DEPTH  = 1024;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic sync_rst_n = 1'b0;
    always #5 clk = ~clk;

    cl_bud_axi_sram_ctrl_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) axi ();

    cl_bud_axi_sram_ctrl #(
        .ID_WIDTH  (ID_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk       (clk),
        .sync_rst_n(sync_rst_n),
        .s_axi     (axi.slave)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] rdat [16];
    int          rlast_cyc;
    logic [3:0]  rr_pat = 4'hF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // awready and arready must never be high together
    always @(negedge clk) begin
        if (sync_rst_n) chk("ready_excl", {63'd0, axi.awready & axi.arready}, 64'd0);
    end

    task automatic idle_bus();
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd3; axi.awburst = INCR; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd3; axi.arburst = INCR; axi.arvalid = 1'b0;
        axi.rready = 1'b1;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int   n = 0;
        logic hs = 1'b0;
        set_aw(id, addr, len, size, burst);
        axi.awvalid = 1'b1;
        do begin
            @(negedge clk); hs = axi.awready;
            @(posedge clk); #1; n++;
        end while (!hs && n < 20);
        axi.awvalid = 1'b0;
        if (!hs) chk("aw_timeout", 64'd0, 64'd1);
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int   n = 0;
        logic hs = 1'b0;
        set_ar(id, addr, len, size, burst);
        axi.arvalid = 1'b1;
        do begin
            @(negedge clk); hs = axi.arready;
            @(posedge clk); #1; n++;
        end while (!hs && n < 20);
        axi.arvalid = 1'b0;
        if (!hs) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    // Drives beats 0..len; wlast is raised only on beat wlast_beat
    task automatic w_phase(input int len, input int wlast_beat);
        for (int i = 0; i <= len; i++) begin
            int   n = 0;
            logic hs = 1'b0;
            axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == wlast_beat);
            do begin
                @(negedge clk); hs = axi.wready;
                if (i == 0 && n == 0) chk("wready_lat", {63'd0, axi.wready}, 64'd1);
                @(posedge clk); #1; n++;
            end while (!hs && n < 20);
            if (!hs) chk("w_timeout", 64'd0, 64'd1);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] exp_resp, input logic [3:0] exp_id);
        @(negedge clk);
        chk("bvalid_lat", {63'd0, axi.bvalid}, 64'd1);
        chk("bresp", {62'd0, axi.bresp}, {62'd0, exp_resp});
        chk("bid", {60'd0, axi.bid}, {60'd0, exp_id});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bvalid_clr", {63'd0, axi.bvalid}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Collects beats into rdat[]; rready follows rr_pat cyclically from the
    // cycle rvalid is first due (AR handshake + 2).
    task automatic r_phase(input int len, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int          beat = 0;
        int          cyc = 0;
        logic        done = 1'b0;
        logic        first = 1'b1;
        logic        holding = 1'b0;
        logic [63:0] held = '0;
        @(negedge clk);
        chk("rvalid_early", {63'd0, axi.rvalid}, 64'd0);
        @(posedge clk); #1;
        axi.rready = rr_pat[0];
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (first) chk("rvalid_lat", {63'd0, axi.rvalid}, 64'd1);
            first = 1'b0;
            if (holding) chk("rdata_stable", axi.rdata, held);
            holding = 1'b0;
            if (axi.rvalid) begin
                if (axi.rready) begin
                    rdat[beat] = axi.rdata;
                    chk("rlast", {63'd0, axi.rlast}, {63'd0, (beat == len)});
                    chk("rresp", {62'd0, axi.rresp}, {62'd0, exp_resp});
                    chk("rid", {60'd0, axi.rid}, {60'd0, exp_id});
                    if (beat == len) begin
                        done = 1'b1;
                        rlast_cyc = cyc;
                    end
                    beat++;
                end else begin
                    held = axi.rdata;
                    holding = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            axi.rready = rr_pat[cyc % 4];
        end
        axi.rready = 1'b1;
        if (!done) chk("r_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [1:0] exp_resp);
        aw_phase(id, addr, 8'(len), 3'd3, burst);
        w_phase(len, len);
        b_phase(exp_resp, id);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [1:0] exp_resp);
        ar_phase(id, addr, 8'(len), 3'd3, burst);
        r_phase(len, id, exp_resp);
    endtask

    // AW and AR presented in the same cycle; checks which one is granted
    task automatic contest(input logic exp_wr, input logic [3:0] wid, input logic [3:0] rid,
                           input logic [31:0] addr);
        set_aw(wid, addr, 8'd0, 3'd3, INCR);
        set_ar(rid, addr, 8'd0, 3'd3, INCR);
        axi.awvalid = 1'b1; axi.arvalid = 1'b1;
        @(negedge clk);
        chk("grant_aw", {63'd0, axi.awready}, {63'd0, exp_wr});
        chk("grant_ar", {63'd0, axi.arready}, {63'd0, !exp_wr});
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.arvalid = 1'b0;
        if (exp_wr) begin
            w_phase(0, 0);
            b_phase(OKAY, wid);
        end else begin
            r_phase(0, rid, OKAY);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        idle_bus();
        sync_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {63'd0, axi.awready}, 64'd0);
        chk("rst_arready", {63'd0, axi.arready}, 64'd0);
        chk("rst_wready",  {63'd0, axi.wready},  64'd0);
        chk("rst_bvalid",  {63'd0, axi.bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, axi.rvalid},  64'd0);
        chk("rst_rlast",   {63'd0, axi.rlast},   64'd0);
        chk("rst_bresp",   {62'd0, axi.bresp},   64'd0);
        chk("rst_rresp",   {62'd0, axi.rresp},   64'd0);
        chk("rst_bid",     {60'd0, axi.bid},     64'd0);
        chk("rst_rid",     {60'd0, axi.rid},     64'd0);
        chk("rst_rdata",   axi.rdata,            64'd0);
        @(posedge clk); #1;
        sync_rst_n = 1'b1;

        // Single-beat write/read
        wd[0] = 64'h0000_0000_000A_BACA; ws[0] = 8'hFF;
        do_write(4'd1, 32'h10, 0, INCR, OKAY);
        do_read(4'd2, 32'h10, 0, INCR, OKAY);
        chk("t1_rdata", rdat[0], 64'h0000_0000_000A_BACA);
        chk("t1_rlast_cyc", 64'(rlast_cyc), 64'd0);

        // INCR len 3 with partial strobe on beat 2 over a zeroed word
        for (int i = 0; i < 4; i++) begin wd[i] = 64'd0; ws[i] = 8'hFF; end
        do_write(4'd3, 32'h100, 3, INCR, OKAY);
        wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'hDEAD_BEEF_0000_0003; wd[3] = 64'd4;
        ws[2] = 8'h0F;
        do_write(4'd3, 32'h100, 3, INCR, OKAY);
        do_read(4'd4, 32'h100, 3, INCR, OKAY);
        chk("t2_beat0", rdat[0], 64'd1);
        chk("t2_beat1", rdat[1], 64'd2);
        chk("t2_beat2", rdat[2], 64'd3);
        chk("t2_beat3", rdat[3], 64'd4);
        chk("t2_rlast_cyc", 64'(rlast_cyc), 64'd3);

        // len 7 read with rready 1,0,0,1
        for (int i = 0; i < 8; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'd5, 32'h200, 7, INCR, OKAY);
        rr_pat = 4'b1001;
        do_read(4'd6, 32'h200, 7, INCR, OKAY);
        rr_pat = 4'hF;
        for (int i = 0; i < 8; i++) chk("t3_beat", rdat[i], 64'hA0 + 64'(i));

        // FIXED write keeps hitting the same word
        wd[0] = 64'h1234; wd[1] = 64'h5678; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd7, 32'h500, 1, FIXED, OKAY);
        do_read(4'd7, 32'h500, 0, INCR, OKAY);
        chk("fixed_rdata", rdat[0], 64'h5678);

        // Out-of-range INCR leaves the last word untouched
        wd[0] = 64'h1111_2222_3333_4444;
        do_write(4'd1, 32'h1FF8, 0, INCR, OKAY);
        wd[0] = 64'hBAD0_BAD0_BAD0_BAD0; wd[1] = 64'hBAD1_BAD1_BAD1_BAD1;
        do_write(4'd2, 32'h1FF8, 1, INCR, SLVERR);
        do_read(4'd3, 32'h1FF8, 0, INCR, OKAY);
        chk("oor_unchanged", rdat[0], 64'h1111_2222_3333_4444);

        // awsize 2 -> SLVERR
        aw_phase(4'd4, 32'h20, 8'd0, 3'd2, INCR);
        w_phase(0, 0);
        b_phase(SLVERR, 4'd4);

        // Early wlast on a 2-beat burst -> SLVERR
        aw_phase(4'd5, 32'h400, 8'd1, 3'd3, INCR);
        w_phase(1, 0);
        b_phase(SLVERR, 4'd5);

        // WRAP read -> SLVERR with zero data
        do_read(4'd6, 32'h100, 3, WRAP, SLVERR);
        for (int i = 0; i < 4; i++) chk("wrap_rdata", rdat[i], 64'd0);

        // Arbitration after reset: write, read, write, read
        sync_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 sync_rst_n = 1'b1;
        wd[0] = 64'h55; ws[0] = 8'hFF;
        contest(1'b1, 4'd8, 4'd9, 32'h300);
        contest(1'b0, 4'd8, 4'd9, 32'h300);
        chk("arb_rd1", rdat[0], 64'h55);
        wd[0] = 64'h66;
        contest(1'b1, 4'd10, 4'd11, 32'h300);
        contest(1'b0, 4'd10, 4'd11, 32'h300);
        chk("arb_rd2", rdat[0], 64'h66);

        // Reset during beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hC0 + 64'(i); ws[i] = 8'hFF; end
        aw_phase(4'd12, 32'h600, 8'd3, 3'd3, INCR);
        w_phase(1, 99);
        axi.wvalid = 1'b1; axi.wdata = wd[2]; axi.wstrb = ws[2];
        sync_rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_wready", {63'd0, axi.wready}, 64'd0);
        chk("mid_rst_bvalid", {63'd0, axi.bvalid}, 64'd0);
        @(posedge clk); #1;
        sync_rst_n = 1'b1; axi.wvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_no_b", {63'd0, axi.bvalid}, 64'd0);
        @(posedge clk); #1;
        wd[0] = 64'hFEED_F00D_0000_0001;
        do_write(4'd13, 32'h600, 0, INCR, OKAY);
        do_read(4'd14, 32'h600, 0, INCR, OKAY);
        chk("post_rst_rdata", rdat[0], 64'hFEED_F00D_0000_0001);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cl_bud_axi_sram_ctrl.md
# cl_bud_axi_sram_ctrl

AXI4 slave memory controller for the bud design, sitting directly downstream of the AXI-L to AXI4 bridge on its `s_axi_*` bus. It accepts single-outstanding INCR/FIXED bursts of 64-bit beats, stores them in an inferred single-port SRAM and returns read bursts with full one-beat-per-cycle throughput through a 2-entry read buffer. Malformed or out-of-range bursts are answered with SLVERR.

## Interface
- `ID_WIDTH`, 4: width of AWID/ARID/BID/RID.
- `ADDR_WIDTH`, 32: byte address width.
- `MEM_DEPTH`, 1024: SRAM depth in 64-bit words; power of two.
- `clk` in 1: sole clock; all logic rising-edge.
- `sync_rst_n` in 1: reset, synchronous, active-low.
- `s_axi_awid/awaddr/awlen/awsize/awburst` in ID_WIDTH/ADDR_WIDTH/8/3/2: write address.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in 64, `s_axi_wstrb` in 8, `s_axi_wlast` in 1: write data.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data handshake.
- `s_axi_bid` out ID_WIDTH, `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response.
- `s_axi_arid/araddr/arlen/arsize/arburst` in ID_WIDTH/ADDR_WIDTH/8/3/2: read address.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address handshake.
- `s_axi_rid` out ID_WIDTH, `s_axi_rdata` out 64, `s_axi_rresp` out 2, `s_axi_rlast` out 1, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA. One transaction in flight.
- IDLE: awready/arready asserted only for the granted channel. Grant: if only one valid, that one; if both, alternate, using last_grant (reset = READ, so first contest goes to write).
- Address phase latches id, len, burst, start word index = addr[ADDR_WIDTH-1:3]; addr[2:0] ignored.
- Error (SLVERR, 2'b10) latched at address phase if: size != 3, burst = WRAP (2'b10) or reserved (2'b11), or INCR with start index + len >= MEM_DEPTH, or FIXED with start index >= MEM_DEPTH. Errored bursts perform no SRAM writes; reads return rdata = 0.
- INCR: index +1 per beat. FIXED: index constant.
- WR_DATA: wready = 1. Each beat writes bytes enabled by wstrb. Beat counter 0..len; burst ends on beat len regardless of wlast. wlast asserted on wrong beat (early or missing on final) -> bresp SLVERR; data for beats already written stays written.
- WR_RESP: bvalid = 1, bid = latched id, bresp = OKAY or SLVERR; held until bready; then IDLE.
- RD_DATA: SRAM reads issued in order while beats remain and (buffer occupancy + in-flight read) < 2. rvalid = buffer non-empty. rid = latched id, rresp per burst, rlast on beat len. IDLE entered the cycle after the rlast handshake.
- SRAM contents are not reset.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 0; bid, rid, rdata = 0; FSM IDLE; buffer empty; last_grant = READ.
- Reset mid-burst: transaction abandoned, no response, buffer flushed, outputs at reset values next cycle.
- AW handshake at edge N: wready high from cycle N+1. Last W handshake at edge M: bvalid high in cycle M+1.
- AR handshake at edge N: first rvalid in cycle N+2. With rready held high, one beat per cycle, rlast for a len-L burst in cycle N+2+L.
- rready low: rvalid, rdata, rlast held stable; at most 2 beats buffered; issue stalls, no beat lost or duplicated.
- awready and arready never high simultaneously; both low outside IDLE.
- len = 0: single beat; wlast and rlast on beat 0.

## Test plan
- Reset, AW/W addr 0x10 data 0x00000000000ABACA strb 0xFF len 0, bready=1 -> bresp OKAY one cycle after W; AR 0x10 -> rdata 0x000ABACA, rlast=1, rvalid at AR+2.
- INCR len 3 write at 0x100 data 1,2,3,4 with wstrb 0x0F on beat 2, then read -> 1, upper-zero/lower-3 merge over prior 0, 4 returned back-to-back, rlast on 4th beat.
- AWVALID and ARVALID asserted in same cycle repeatedly -> grants write, read, write, read alternating; no response reordering.
- Read len 7 with rready toggling 1,0,0,1 -> all 8 beats in order, rdata stable while stalled, no more than 2 buffered.
- Write len 1 at word MEM_DEPTH-1 -> bresp SLVERR, word MEM_DEPTH-1 unchanged; awsize 2 -> SLVERR; read WRAP -> rresp SLVERR, rdata 0.
- sync_rst_n low mid write burst (beat 2 of 4) -> wready 0 next cycle, no bvalid; subsequent clean write/read pass.
